// File: rtl/mac_pkg.sv
// Shared definitions for the MAC array and its operand feeder.
// Default geometry, feeder FSM encoding and the accumulator width owned by the MAC.
package mac_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ROWS   = 8;
    localparam int DEF_DEPTH  = 8;
    localparam int ACC_W      = 24;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FEED  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } feeder_state_t;

endpackage

// File: rtl/mac_feed_buf.sv
// A (ROWS x DEPTH) and B (DEPTH) operand register file with one write port.
// Combinational read of B[t] and the skewed diagonal A[r][t-r] for every row.
module mac_feed_buf
    import mac_pkg::*;
#(
    parameter int ROWS   = DEF_ROWS,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int DATA_W = DEF_DATA_W,
    parameter int T_W    = $clog2(DEPTH + ROWS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en_i,
    input  logic                     wr_sel_i,
    input  logic [$clog2(ROWS)-1:0]  wr_row_i,
    input  logic [$clog2(DEPTH)-1:0] wr_idx_i,
    input  logic [DATA_W-1:0]        wr_data_i,
    input  logic [T_W-1:0]           rd_t_i,
    output logic [DATA_W-1:0]        rd_b_o,
    output logic [ROWS*DATA_W-1:0]   rd_a_o
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [DATA_W-1:0] a_q [ROWS][DEPTH];
    logic [DATA_W-1:0] b_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int k = 0; k < DEPTH; k++) begin
                    a_q[r][k] <= '0;
                end
            end
            for (int k = 0; k < DEPTH; k++) begin
                b_q[k] <= '0;
            end
        end else if (wr_en_i) begin
            if (wr_sel_i) begin
                b_q[wr_idx_i] <= wr_data_i;
            end else begin
                a_q[wr_row_i][wr_idx_i] <= wr_data_i;
            end
        end
    end

    // Row r lags the B wavefront by r cycles, matching one hop per MAC.
    always_comb begin
        rd_b_o = '0;
        rd_a_o = '0;
        if (int'(rd_t_i) < DEPTH) begin
            rd_b_o = b_q[rd_t_i[IDX_W-1:0]];
        end
        for (int r = 0; r < ROWS; r++) begin
            if ((int'(rd_t_i) >= r) && ((int'(rd_t_i) - r) < DEPTH)) begin
                rd_a_o[r*DATA_W +: DATA_W] = a_q[r][IDX_W'(int'(rd_t_i) - r)];
            end
        end
    end

endmodule

// File: rtl/mac_feeder.sv
// Operand scheduler for one matrix-vector product on a systolic MAC chain:
// clear all MACs, stream B/enable into the chain head and skewed A per row, then signal done.
module mac_feeder
    import mac_pkg::*;
#(
    parameter int ROWS   = DEF_ROWS,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic                     wr_sel,
    input  logic [$clog2(ROWS)-1:0]  wr_row,
    input  logic [$clog2(DEPTH)-1:0] wr_idx,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     clr_out,
    output logic                     en_out,
    output logic [DATA_W-1:0]        b_out,
    output logic [ROWS*DATA_W-1:0]   a_out,
    output feeder_state_t            dbg_state_o
);

    localparam int T_W       = $clog2(DEPTH + ROWS);
    localparam int FEED_LAST = DEPTH + ROWS - 2;

    feeder_state_t state_q, state_d;
    logic [T_W-1:0] t_q, t_d;

    logic                   busy_q, done_q, clr_q, en_q;
    logic [DATA_W-1:0]      bout_q;
    logic [ROWS*DATA_W-1:0] aout_q;

    logic                   buf_wr;
    logic                   feed_d;
    logic [DATA_W-1:0]      rd_b;
    logic [ROWS*DATA_W-1:0] rd_a;

    // The buffer is frozen for the whole run, so a write in the start cycle still lands first.
    assign buf_wr = wr_en && (state_q == IDLE);

    mac_feed_buf #(
        .ROWS   (ROWS),
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .T_W    (T_W)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (buf_wr),
        .wr_sel_i  (wr_sel),
        .wr_row_i  (wr_row),
        .wr_idx_i  (wr_idx),
        .wr_data_i (wr_data),
        .rd_t_i    (t_d),
        .rd_b_o    (rd_b),
        .rd_a_o    (rd_a)
    );

    // t is the feed index in FEED and the drain cycle count in DRAIN.
    always_comb begin
        state_d = state_q;
        t_d     = '0;
        case (state_q)
            IDLE:  if (start) state_d = CLEAR;
            CLEAR: state_d = FEED;
            FEED: begin
                if (t_q == T_W'(FEED_LAST)) state_d = DRAIN;
                else                        t_d = t_q + 1'b1;
            end
            DRAIN: begin
                if (t_q == T_W'(1)) state_d = DONE;
                else                t_d = t_q + 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign feed_d = (state_d == FEED);

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            t_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            clr_q   <= 1'b0;
            en_q    <= 1'b0;
            bout_q  <= '0;
            aout_q  <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_d == DONE);
            clr_q   <= (state_d == CLEAR);
            en_q    <= feed_d && (int'(t_d) < DEPTH);
            bout_q  <= feed_d ? rd_b : '0;
            aout_q  <= feed_d ? rd_a : '0;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign clr_out     = clr_q;
    assign en_out      = en_q;
    assign b_out       = bout_q;
    assign a_out       = aout_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mac_feeder.sv
// Bench for mac_feeder: cycle tables, skew sweep and a behavioural MAC chain
// whose accumulators are compared against dot products computed from a mirror of A/B.
module tb_mac_feeder;
    import mac_pkg::*;

    localparam int ROWS   = DEF_ROWS;
    localparam int DEPTH  = DEF_DEPTH;
    localparam int DATA_W = DEF_DATA_W;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     wr_en = 1'b0;
    logic                     wr_sel = 1'b0;
    logic [$clog2(ROWS)-1:0]  wr_row = '0;
    logic [$clog2(DEPTH)-1:0] wr_idx = '0;
    logic [DATA_W-1:0]        wr_data = '0;
    logic                     start = 1'b0;
    logic                     busy, done, clr_out, en_out;
    logic [DATA_W-1:0]        b_out;
    logic [ROWS*DATA_W-1:0]   a_out;
    feeder_state_t            dbg_state;

    mac_feeder dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_sel      (wr_sel),
        .wr_row      (wr_row),
        .wr_idx      (wr_idx),
        .wr_data     (wr_data),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .clr_out     (clr_out),
        .en_out      (en_out),
        .b_out       (b_out),
        .a_out       (a_out),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    // Behavioural MAC chain: En/Bin hop one MAC per cycle, product register, then accumulate.
    logic              m_hen  [ROWS+1];
    logic [7:0]        m_hb   [ROWS+1];
    logic              m_pv   [ROWS];
    logic [15:0]       m_prod [ROWS];
    logic [ACC_W-1:0]  m_acc  [ROWS];
    logic              ein;
    logic [7:0]        bin, ain;

    always @(posedge clk) begin
        for (int r = 0; r < ROWS; r++) begin
            ein = (r == 0) ? en_out : m_hen[r];
            bin = (r == 0) ? b_out  : m_hb[r];
            ain = a_out[r*DATA_W +: DATA_W];
            if (clr_out) begin
                m_acc[r] <= '0;
                m_pv[r]  <= 1'b0;
            end else begin
                m_pv[r] <= ein;
                if (ein)     m_prod[r] <= 16'(ain) * 16'(bin);
                if (m_pv[r]) m_acc[r]  <= m_acc[r] + ACC_W'(m_prod[r]);
            end
            m_hen[r+1] <= ein;
            m_hb[r+1]  <= bin;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]       ma [ROWS][DEPTH];
    logic [7:0]       mb [DEPTH];
    logic [ACC_W-1:0] gold [ROWS];

    typedef struct {
        int          cyc;
        bit          busy;
        bit          clr;
        bit          en;
        bit          done;
        logic [7:0]  b;
        logic [63:0] a;
    } vec_t;

    vec_t tab [11];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wr(input bit sel, input int row, input int idx, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_row  = 3'(row);
        wr_idx  = 3'(idx);
        wr_data = d;
        step();
        wr_en   = 1'b0;
        if (sel) mb[idx] = d;
        else     ma[row][idx] = d;
    endtask

    task automatic clear_mirror();
        for (int r = 0; r < ROWS; r++)
            for (int k = 0; k < DEPTH; k++) ma[r][k] = '0;
        for (int k = 0; k < DEPTH; k++) mb[k] = '0;
    endtask

    task automatic calc_gold();
        for (int r = 0; r < ROWS; r++) begin
            gold[r] = '0;
            for (int k = 0; k < DEPTH; k++)
                gold[r] = gold[r] + ACC_W'(ma[r][k]) * ACC_W'(mb[k]);
        end
    endtask

    // Starts a run in the current cycle, checks clr, done latency and every accumulator.
    task automatic do_run(input string tag, output logic [71:0] seen);
        int cyc;
        calc_gold();
        seen  = '0;
        start = 1'b1;
        step();
        start = 1'b0;
        wr_en = 1'b0;
        cyc   = 1;
        chk({tag, "_clr"}, 64'(clr_out), 64'd1);
        while (!done && cyc < 40) begin
            seen = seen | {b_out, a_out};
            step();
            cyc++;
        end
        chk({tag, "_done_lat"}, 64'(cyc), 64'd19);
        for (int r = 0; r < ROWS; r++)
            chk($sformatf("%s_cout%0d", tag, r), 64'(m_acc[r]), 64'(gold[r]));
    endtask

    initial begin
        logic [71:0] seen;
        logic [63:0] exp_a;
        int cur;

        tab[0]  = '{1,  1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 64'h0};
        tab[1]  = '{2,  1'b1, 1'b0, 1'b1, 1'b0, 8'd1, 64'h1};
        tab[2]  = '{3,  1'b1, 1'b0, 1'b1, 1'b0, 8'd2, 64'h0};
        tab[3]  = '{4,  1'b1, 1'b0, 1'b1, 1'b0, 8'd3, 64'h100};
        tab[4]  = '{9,  1'b1, 1'b0, 1'b1, 1'b0, 8'd8, 64'h0};
        tab[5]  = '{10, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 64'h0000_0001_0000_0000};
        tab[6]  = '{16, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 64'h0100_0000_0000_0000};
        tab[7]  = '{17, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 64'h0};
        tab[8]  = '{18, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 64'h0};
        tab[9]  = '{19, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0, 64'h0};
        tab[10] = '{20, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 64'h0};

        clear_mirror();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();

        chk("rst_state", 64'(dbg_state), 64'(IDLE));
        chk("rst_busy",  64'(busy),      64'd0);
        chk("rst_done",  64'(done),      64'd0);
        chk("rst_clr",   64'(clr_out),   64'd0);
        chk("rst_en",    64'(en_out),    64'd0);
        chk("rst_b",     64'(b_out),     64'd0);
        chk("rst_a",     64'(a_out),     64'd0);

        // Identity A, B = 1..8: cycle-accurate table against hand-computed outputs.
        for (int k = 0; k < DEPTH; k++) wr(1'b1, 0, k, 8'(k + 1));
        for (int r = 0; r < ROWS; r++)  wr(1'b0, r, r, 8'd1);
        start = 1'b1;
        step();
        start = 1'b0;
        cur = 1;
        for (int i = 0; i < 11; i++) begin
            while (cur < tab[i].cyc) begin
                step();
                cur++;
            end
            chk($sformatf("tab%0d_busy", tab[i].cyc), 64'(busy),    64'(tab[i].busy));
            chk($sformatf("tab%0d_clr",  tab[i].cyc), 64'(clr_out), 64'(tab[i].clr));
            chk($sformatf("tab%0d_en",   tab[i].cyc), 64'(en_out),  64'(tab[i].en));
            chk($sformatf("tab%0d_done", tab[i].cyc), 64'(done),    64'(tab[i].done));
            chk($sformatf("tab%0d_b",    tab[i].cyc), 64'(b_out),   64'(tab[i].b));
            chk($sformatf("tab%0d_a",    tab[i].cyc), a_out,        tab[i].a);
        end
        for (int r = 0; r < ROWS; r++)
            chk($sformatf("ident_cout%0d", r), 64'(m_acc[r]), 64'(r + 1));

        // Skew sweep: A[r][k] = 16r+k, window t = r..r+7 per row.
        for (int r = 0; r < ROWS; r++)
            for (int k = 0; k < DEPTH; k++) wr(1'b0, r, k, 8'(16 * r + k));
        calc_gold();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        for (int t = 0; t <= DEPTH + ROWS - 2; t++) begin
            exp_a = '0;
            for (int r = 0; r < ROWS; r++)
                if (t >= r && t - r < DEPTH) exp_a[r*8 +: 8] = 8'(16 * r + (t - r));
            chk($sformatf("skew_a_t%0d", t),  a_out,        exp_a);
            chk($sformatf("skew_en_t%0d", t), 64'(en_out),  64'(t < DEPTH));
            step();
        end
        cur = 0;
        while (!done && cur < 10) begin
            step();
            cur++;
        end
        chk("skew_done_seen", 64'(done), 64'd1);
        for (int r = 0; r < ROWS; r++)
            chk($sformatf("skew_cout%0d", r), 64'(m_acc[r]), 64'(gold[r]));
        step();

        // All 0xFF: largest dot product must fit the accumulator.
        for (int r = 0; r < ROWS; r++)
            for (int k = 0; k < DEPTH; k++) wr(1'b0, r, k, 8'hFF);
        for (int k = 0; k < DEPTH; k++) wr(1'b1, 0, k, 8'hFF);
        do_run("ff", seen);
        for (int r = 0; r < ROWS; r++)
            chk($sformatf("ff_const%0d", r), 64'(m_acc[r]), 64'd520200);
        step();

        // Start and writes while busy are dropped; a rerun shows the buffer unchanged.
        calc_gold();
        start = 1'b1;
        step();
        start = 1'b0;
        cur = 1;
        while (cur < 6) begin
            step();
            cur++;
        end
        start = 1'b1; wr_en = 1'b1; wr_sel = 1'b1; wr_idx = 3'd0; wr_data = 8'h00;
        step();
        cur++;
        start = 1'b0; wr_en = 1'b0;
        while (!done && cur < 40) begin
            step();
            cur++;
        end
        chk("busy_done_lat", 64'(cur), 64'd19);
        for (int r = 0; r < ROWS; r++)
            chk($sformatf("busy_cout%0d", r), 64'(m_acc[r]), 64'(gold[r]));
        wr_en = 1'b1; wr_sel = 1'b1; wr_idx = 3'd1; wr_data = 8'h01;
        step();
        wr_en = 1'b0;
        do_run("rerun", seen);

        // Back-to-back: start in the cycle after done, with a write in that same cycle.
        step();
        wr_en = 1'b1; wr_sel = 1'b1; wr_idx = 3'd2; wr_data = 8'h10;
        mb[2] = 8'h10;
        do_run("b2b1", seen);
        step();
        wr_en = 1'b1; wr_sel = 1'b0; wr_row = 3'd5; wr_idx = 3'd3; wr_data = 8'h02;
        ma[5][3] = 8'h02;
        do_run("b2b2", seen);
        step();

        // Reset mid-FEED at t=5 clears state, outputs and buffer.
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (6) step();
        chk("midrst_pre_en", 64'(en_out), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_state", 64'(dbg_state), 64'(IDLE));
        chk("midrst_busy",  64'(busy),      64'd0);
        chk("midrst_en",    64'(en_out),    64'd0);
        chk("midrst_a",     64'(a_out),     64'd0);
        chk("midrst_b",     64'(b_out),     64'd0);
        chk("midrst_clr",   64'(clr_out),   64'd0);
        clear_mirror();
        do_run("postrst", seen);
        chk("postrst_reads_zero", 64'(seen[63:0]) | 64'(seen[71:64]), 64'd0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
